// File: rtl/hand_cricket_pkg.sv
// Shared types and encodings for the two-innings hand-cricket match controller.
package hand_cricket_pkg;

    typedef enum logic [1:0] {
        INN1  = 2'd0,
        BREAK = 2'd1,
        INN2  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

endpackage

// File: rtl/hand_cricket_match_if.sv
// Board-side signal bundle: hand/button inputs and score/status display outputs.
interface hand_cricket_match_if #(
    parameter int RUN_W         = 3,
    parameter int SCORE_W       = 8,
    parameter int MAX_WICKETS   = 3,
    parameter int BALLS_PER_INN = 12
);
    localparam int WK_W = $clog2(MAX_WICKETS + 1);
    localparam int BL_W = $clog2(BALLS_PER_INN + 1);

    logic [RUN_W-1:0]   player1_run;
    logic [RUN_W-1:0]   player2_run;
    logic               input_gate;
    logic               btn_play;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W:0]   target;
    logic [WK_W-1:0]    wickets;
    logic [BL_W-1:0]    balls;
    logic               innings;
    logic               out_flag;
    logic               match_over;
    logic [1:0]         winner;

    modport master (
        output player1_run, player2_run, input_gate, btn_play,
        input  score, target, wickets, balls, innings, out_flag, match_over, winner
    );

    modport slave (
        input  player1_run, player2_run, input_gate, btn_play,
        output score, target, wickets, balls, innings, out_flag, match_over, winner
    );

endinterface

// File: rtl/hc_edge_detect.sv
// Single rising-edge pulse generator; pulse is combinational from the level and its history.
module hc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= 1'b0;
        else       prev <= level;
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/hand_cricket_match.sv
// Two-innings hand-cricket controller: ball scoring, wickets, ball limit, chase and result.
module hand_cricket_match
    import hand_cricket_pkg::*;
#(
    parameter int RUN_W         = 3,
    parameter int SCORE_W       = 8,
    parameter int MAX_WICKETS   = 3,
    parameter int BALLS_PER_INN = 12
) (
    input logic              clk,
    input logic              reset,
    hand_cricket_match_if.slave bus
);
    localparam int WK_W = $clog2(MAX_WICKETS + 1);
    localparam int BL_W = $clog2(BALLS_PER_INN + 1);

    state_t             state;
    logic [RUN_W-1:0]   p1_reg, p2_reg;
    logic               pending;
    logic               gate_pulse, play_pulse;

    logic               ball_taken, is_wicket, exhausted, chased, tied;
    logic [RUN_W-1:0]   batter_run;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] nxt_score;
    logic [WK_W-1:0]    nxt_wk;
    logic [BL_W-1:0]    nxt_balls;

    hc_edge_detect u_gate_edge (.clk(clk), .reset(reset), .level(bus.input_gate), .pulse(gate_pulse));
    hc_edge_detect u_play_edge (.clk(clk), .reset(reset), .level(bus.btn_play),   .pulse(play_pulse));

    // Post-ball values; end-of-innings decisions are taken on these, not on the registers.
    always_comb begin
        ball_taken = play_pulse & pending & ((state == INN1) || (state == INN2));
        batter_run = (state == INN2) ? p2_reg : p1_reg;
        is_wicket  = (p1_reg == p2_reg);
        sum        = {1'b0, bus.score} + (SCORE_W + 1)'(batter_run);
        nxt_score  = bus.score;
        if (!is_wicket) nxt_score = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        nxt_wk     = is_wicket ? bus.wickets + WK_W'(1) : bus.wickets;
        nxt_balls  = bus.balls + BL_W'(1);
        exhausted  = (nxt_wk == WK_W'(MAX_WICKETS)) || (nxt_balls == BL_W'(BALLS_PER_INN));
        chased     = ({1'b0, nxt_score} >= bus.target);
        tied       = ({1'b0, nxt_score} == bus.target - (SCORE_W + 1)'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= INN1;
            p1_reg         <= '0;
            p2_reg         <= '0;
            pending        <= 1'b0;
            bus.score      <= '0;
            bus.target     <= '0;
            bus.wickets    <= '0;
            bus.balls      <= '0;
            bus.innings    <= 1'b0;
            bus.out_flag   <= 1'b0;
            bus.match_over <= 1'b0;
            bus.winner     <= WIN_NONE;
        end else begin
            if (gate_pulse && state != DONE) begin
                p1_reg <= bus.player1_run;
                p2_reg <= bus.player2_run;
            end
            case (state)
                INN1, INN2: begin
                    pending <= gate_pulse | (pending & ~ball_taken);
                    if (ball_taken) begin
                        bus.balls    <= nxt_balls;
                        bus.wickets  <= nxt_wk;
                        bus.score    <= nxt_score;
                        bus.out_flag <= is_wicket;
                        if (state == INN1) begin
                            if (exhausted) begin
                                state      <= BREAK;
                                bus.target <= {1'b0, nxt_score} + (SCORE_W + 1)'(1);
                            end
                        end else if (chased) begin
                            state          <= DONE;
                            bus.match_over <= 1'b1;
                            bus.winner     <= WIN_P2;
                        end else if (exhausted) begin
                            state          <= DONE;
                            bus.match_over <= 1'b1;
                            bus.winner     <= tied ? WIN_TIE : WIN_P1;
                        end
                    end
                end
                BREAK: begin
                    if (play_pulse) begin
                        state        <= INN2;
                        pending      <= 1'b0;
                        bus.innings  <= 1'b1;
                        bus.score    <= '0;
                        bus.wickets  <= '0;
                        bus.balls    <= '0;
                        bus.out_flag <= 1'b0;
                    end else begin
                        pending <= gate_pulse | pending;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hand_cricket_match.sv
// Directed bench: two instances (8-bit and 4-bit score) driven with identical stimulus.
module tb_hand_cricket_match;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    hand_cricket_match_if #(.RUN_W(3), .SCORE_W(8), .MAX_WICKETS(2), .BALLS_PER_INN(4)) ifa ();
    hand_cricket_match_if #(.RUN_W(3), .SCORE_W(4), .MAX_WICKETS(2), .BALLS_PER_INN(4)) ifb ();

    hand_cricket_match #(.RUN_W(3), .SCORE_W(8), .MAX_WICKETS(2), .BALLS_PER_INN(4)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    hand_cricket_match #(.RUN_W(3), .SCORE_W(4), .MAX_WICKETS(2), .BALLS_PER_INN(4)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_hands(input int a, input int b);
        ifa.player1_run = 3'(a); ifa.player2_run = 3'(b);
        ifb.player1_run = 3'(a); ifb.player2_run = 3'(b);
    endtask

    task automatic set_gate(input logic v);
        ifa.input_gate = v; ifb.input_gate = v;
    endtask

    task automatic set_play(input logic v);
        ifa.btn_play = v; ifb.btn_play = v;
    endtask

    task automatic gate(input int a, input int b);
        @(negedge clk); set_hands(a, b); set_gate(1'b1);
        @(negedge clk); set_gate(1'b0);
    endtask

    task automatic play();
        @(negedge clk); set_play(1'b1);
        @(negedge clk); set_play(1'b0);
    endtask

    task automatic ball(input int a, input int b);
        gate(a, b);
        play();
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic check_a(input string tag, input int sc, input int tg, input int wk,
                           input int bl, input int inn, input int of, input int mo, input int wn);
        check({tag, ".score"},      int'(ifa.score),      sc);
        check({tag, ".target"},     int'(ifa.target),     tg);
        check({tag, ".wickets"},    int'(ifa.wickets),    wk);
        check({tag, ".balls"},      int'(ifa.balls),      bl);
        check({tag, ".innings"},    int'(ifa.innings),    inn);
        check({tag, ".out_flag"},   int'(ifa.out_flag),   of);
        check({tag, ".match_over"}, int'(ifa.match_over), mo);
        check({tag, ".winner"},     int'(ifa.winner),     wn);
    endtask

    initial begin
        set_hands(0, 0); set_gate(1'b0); set_play(1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check_a("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Basic innings 1 scoring and wickets
        play();
        check("nogate.balls", int'(ifa.balls), 0);
        ball(3, 5);
        ball(6, 2);
        check_a("runs", 9, 0, 0, 2, 0, 0, 0, 0);
        ball(4, 4);
        check_a("wkt1", 9, 0, 1, 3, 0, 1, 0, 0);
        ball(4, 4);
        check_a("brk", 9, 10, 2, 4, 0, 1, 0, 0);
        play();
        check_a("inn2start", 0, 10, 0, 0, 1, 0, 0, 0);
        play();
        check("brk_pending_clr.balls", int'(ifa.balls), 0);

        // Chase won mid-innings
        do_reset();
        ball(5, 1);
        ball(2, 2);
        ball(3, 3);
        check("chase.target", int'(ifa.target), 6);
        play();
        ball(1, 6);
        check_a("chase_win", 6, 6, 0, 1, 1, 0, 1, 2);
        ball(3, 1);
        check("done_hold.balls", int'(ifa.balls), 1);
        check("done_hold.score", int'(ifa.score), 6);

        // Tie on ball limit
        do_reset();
        ball(4, 0); ball(1, 1); ball(2, 2);
        check("tie.target", int'(ifa.target), 5);
        play();
        ball(0, 1); ball(0, 3); ball(1, 0);
        check_a("tie_b3", 4, 5, 0, 3, 1, 0, 0, 0);
        ball(2, 0);
        check_a("tie", 4, 5, 0, 4, 1, 0, 1, 3);

        // Loss on ball limit
        do_reset();
        ball(4, 0); ball(1, 1); ball(2, 2);
        play();
        ball(0, 1); ball(0, 2); ball(1, 0); ball(2, 0);
        check_a("loss", 3, 5, 0, 4, 1, 0, 1, 1);

        // Gate held high latches once; gate and play together use old hands
        do_reset();
        @(negedge clk); set_hands(2, 5); set_gate(1'b1);
        repeat (5) @(negedge clk);
        set_gate(1'b0);
        play();
        check("held.score", int'(ifa.score), 2);
        check("held.balls", int'(ifa.balls), 1);
        play();
        check("held_once.balls", int'(ifa.balls), 1);
        gate(3, 1);
        @(negedge clk); set_hands(6, 0); set_gate(1'b1); set_play(1'b1);
        @(negedge clk); set_gate(1'b0); set_play(1'b0);
        check("same.score", int'(ifa.score), 5);
        check("same.balls", int'(ifa.balls), 2);
        play();
        check("same_pend.score", int'(ifa.score), 11);
        check("same_pend.balls", int'(ifa.balls), 3);

        // Saturation on the 4-bit score instance, then reset mid innings 2
        do_reset();
        ball(7, 0); ball(7, 0); ball(7, 0);
        check("sat.b_score", int'(ifb.score), 15);
        check("sat.a_score", int'(ifa.score), 21);
        ball(7, 0);
        check("sat.b_score4", int'(ifb.score), 15);
        check("sat.b_target", int'(ifb.target), 16);
        check("sat.a_target", int'(ifa.target), 29);
        play();
        ball(0, 7); ball(0, 7);
        check("sat_inn2.b_score", int'(ifb.score), 14);
        check("sat_inn2.b_innings", int'(ifb.innings), 1);
        @(negedge clk); reset = 1'b1;
        #1;
        check("async.b_score", int'(ifb.score), 0);
        @(negedge clk);
        check("rst.b_score",   int'(ifb.score),   0);
        check("rst.b_target",  int'(ifb.target),  0);
        check("rst.b_balls",   int'(ifb.balls),   0);
        check("rst.b_innings", int'(ifb.innings), 0);
        check_a("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        ball(2, 1);
        check("post_rst.score", int'(ifa.score), 2);
        check("post_rst.innings", int'(ifa.innings), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hand_cricket_match.md
Name: hand_cricket_match

Overview:
- Parametrised two-innings hand-cricket match controller; successor to the single-innings score/out block.
- Adds multi-wicket innings, a ball limit per innings, a target chase by the second batter, and winner resolution.
- Sits between the board switches/buttons (run selectors, gate, play) and the LED/status display logic.

Parameters:
- RUN_W, 3, width of each player's run input.
- SCORE_W, 8, width of the innings score and target registers.
- MAX_WICKETS, 3, wickets that end an innings (>=1).
- BALLS_PER_INN, 12, legal balls per innings (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- player1_run  input  RUN_W  player 1 hand value
- player2_run  input  RUN_W  player 2 hand value
- input_gate  input  1  level; rising edge latches both hand values
- btn_play  input  1  level; rising edge plays the latched ball / advances phase
- score  output  SCORE_W  current innings score
- target  output  SCORE_W+1  innings-1 score + 1 (0 during innings 1)
- wickets  output  $clog2(MAX_WICKETS+1)  wickets fallen this innings
- balls  output  $clog2(BALLS_PER_INN+1)  balls bowled this innings
- innings  output  1  0 = player 1 batting, 1 = player 2 batting
- out_flag  output  1  last played ball was a wicket
- match_over  output  1  result decided
- winner  output  2  00 none, 01 player 1, 10 player 2, 11 tie

Behaviour:
- Reset (async, active-high): all outputs 0; state INN1; pending=0; edge-detect history=0.
- Edge detect: gate_pulse = input_gate & ~gate_prev; play_pulse = btn_play & ~play_prev; history registers update every cycle.
- gate_pulse latches p1_reg/p2_reg and sets pending.
- pending next = gate_pulse | (pending & ~ball_taken).
- If gate_pulse and play_pulse occur in the same cycle, the ball uses the previously latched values; the new values are latched and pending remains 1.
- States: INN1, BREAK, INN2, DONE.
- Ball (INN1/INN2, play_pulse & pending):
  - balls +1.
  - p1_reg == p2_reg: wicket; wickets +1, out_flag=1, score unchanged.
  - Otherwise out_flag=0; score += batter's value (p1_reg in INN1, p2_reg in INN2), zero-extended, saturating at 2^SCORE_W-1.
- play_pulse with pending=0 in INN1/INN2 is ignored; no output changes.
- Registered outputs update at the same clock edge that samples play_pulse.
- INN1 end (evaluated on post-ball values):
  - Condition: wickets == MAX_WICKETS or balls == BALLS_PER_INN.
  - Next state BREAK; target = score + 1, width SCORE_W+1, so no overflow.
  - score, wickets, balls and out_flag hold their final values in BREAK for display.
- BREAK + play_pulse -> INN2: innings=1; score, wickets, balls, out_flag cleared; pending cleared; the ball is not consumed.
- INN2 end (checked in this order, on post-ball values):
  - score >= target -> winner=10, immediately, even mid-over.
  - wickets == MAX_WICKETS or balls == BALLS_PER_INN: score == target-1 -> winner=11; else winner=01.
  - On any INN2 end: DONE, match_over=1.
- DONE: all inputs ignored; outputs hold until reset.
- Saturated innings-1 score: target = 2^SCORE_W, which is unreachable. Innings 2 can then at best tie at saturation.
- Reset mid-match returns to INN1 immediately, with all outputs cleared.

Decomposition:
- hand_cricket_pkg:
  - state enum (INN1, BREAK, INN2, DONE).
  - winner encoding constants (WIN_NONE, WIN_P1, WIN_P2, WIN_TIE).
- Sub-module hc_edge_detect: one rising-edge pulse generator (clk, reset, level in, pulse out). Instantiated twice, for gate and play.

Test Plan:
- MAX_WICKETS=2, BALLS_PER_INN=4. Gate (3,5), play; gate (6,2), play -> score=9, balls=2, wickets=0, out_flag=0.
- Same params. Gate (4,4), play -> wickets=1, out_flag=1, score unchanged. Second equal ball -> state BREAK, target = score + 1.
- Chase:
  - Innings 1 = 5 runs; BREAK, play -> innings=1 with counters cleared.
  - Gate (1,6), play -> score=6 >= target=6 -> match_over=1, winner=10, with balls remaining.
- Tie and loss:
  - Innings 1 = 4. Innings 2 exhausts 4 balls at exactly 4 -> winner=11.
  - Repeat with innings 2 finishing at 3 -> winner=01.
- Play without gate is ignored (balls stays 0). Gate held high for 5 cycles latches once. Gate and play in the same cycle use the old values and keep pending=1.
- SCORE_W=4: repeated 7-run balls saturate score at 15. Assert reset mid-INN2 -> next cycle all outputs 0 and innings=0.
